// File: rtl/fpga_rst_seq_pkg.sv
// Shared definitions for the FPGA reset sequencer.
// - rst_state_e : sequencer FSM encoding (WAIT_LOCK, HOLD, RUN)
// - RST_CAUSE_* : reset-cause codes, also decoded by the SoC status register
// - sat_inc8    : saturating 8-bit increment used by the reset counter
package fpga_rst_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } rst_state_e;

   localparam logic [1:0] RST_CAUSE_POR = 2'b00;
   localparam logic [1:0] RST_CAUSE_BTN = 2'b01;
   localparam logic [1:0] RST_CAUSE_PLL = 2'b10;
   localparam logic [1:0] RST_CAUSE_SW  = 2'b11;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/fpga_rst_seq_if.sv
// Board/SoC-side signal bundle of the reset sequencer.
// - btn_rst_n  : raw board reset button, active-low, asynchronous
// - pll_locked : clock-wizard locked flag, asynchronous
// - sw_rst_req : SoC reset request, sequencer clock domain
// - sys_rst_n  : registered active-low reset to the SoC
// - rst_busy   : sequencer not in RUN
// - rst_cause  : last reset cause (RST_CAUSE_* codes)
// - rst_cnt    : reset entries since POR, saturating
// master = sequencer side, slave = board/SoC side.
interface fpga_rst_seq_if;
   logic       btn_rst_n;
   logic       pll_locked;
   logic       sw_rst_req;
   logic       sys_rst_n;
   logic       rst_busy;
   logic [1:0] rst_cause;
   logic [7:0] rst_cnt;

   modport master (
      input  btn_rst_n, pll_locked, sw_rst_req,
      output sys_rst_n, rst_busy, rst_cause, rst_cnt
   );

   modport slave (
      output btn_rst_n, pll_locked, sw_rst_req,
      input  sys_rst_n, rst_busy, rst_cause, rst_cnt
   );
endinterface

// File: rtl/fpga_rst_seq_rst_debounce.sv
// Input conditioning for the reset sequencer.
// - Synchronises the raw button and the PLL locked flag (SYNC_STAGES flops each).
// - Debounces the synchronised button: the output follows only after
//   DEBOUNCE_CYC consecutive cycles of disagreement (press and release alike).
// Ports: clk_i, rst_n_i (async low), btn_raw_n, locked_raw in;
//        deb_btn_n (debounced button, active-low), sync_locked out.
module rst_debounce #(
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 20000
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic btn_raw_n,
   input  logic locked_raw,
   output logic deb_btn_n,
   output logic sync_locked
);
   localparam int DB_W = $clog2(DEBOUNCE_CYC);

   logic [SYNC_STAGES-1:0] btn_sync;
   logic [SYNC_STAGES-1:0] lock_sync;
   logic [DB_W-1:0]        db_cnt;
   logic                   sync_btn_n;

   // Preset to "button released, not locked" so nothing spurious leaks out of reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         btn_sync  <= '1;
         lock_sync <= '0;
      end else begin
         btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_raw_n};
         lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked_raw};
      end
   end

   assign sync_btn_n  = btn_sync[SYNC_STAGES-1];
   assign sync_locked = lock_sync[SYNC_STAGES-1];

   // db_cnt counts consecutive disagreeing cycles; any agreement restarts it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         deb_btn_n <= 1'b1;
         db_cnt    <= '0;
      end else if (sync_btn_n == deb_btn_n) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
         deb_btn_n <= sync_btn_n;
         db_cnt    <= '0;
      end else begin
         db_cnt <= db_cnt + DB_W'(1);
      end
   end
endmodule

// File: rtl/fpga_rst_seq.sv
// FPGA reset sequencer feeding the SoC external reset pad.
// Combines board button, PLL lock and SoC software/watchdog request; releases
// the SoC reset on a clock edge after HOLD_CYC clean cycles and records the
// cause and number of resets taken out of RUN.
// Ports: clk_i (only clock), rst_n_i (async power-on reset, active-low),
//        rst_bus (fpga_rst_seq_if.master: button/lock/request in,
//        sys_rst_n/rst_busy/rst_cause/rst_cnt out).
module fpga_rst_seq
   import fpga_rst_seq_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 20000,
   parameter int HOLD_CYC     = 1024
) (
   input logic            clk_i,
   input logic            rst_n_i,
   fpga_rst_seq_if.master rst_bus
);
   localparam int HW = $clog2(HOLD_CYC);

   logic            deb_btn_n;
   logic            sync_locked;
   logic            hold_ok;
   rst_state_e      state, state_nxt;
   logic [HW-1:0]   hold_cnt, hold_nxt;
   logic [1:0]      cause, cause_nxt;
   logic [7:0]      rst_cnt, cnt_nxt;
   logic            sys_rst_n;

   rst_debounce #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_debounce (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .btn_raw_n   (rst_bus.btn_rst_n),
      .locked_raw  (rst_bus.pll_locked),
      .deb_btn_n   (deb_btn_n),
      .sync_locked (sync_locked)
   );

   // sys_rst_n is registered from the next state so it rises on the edge
   // entering RUN and falls on the edge leaving it, never combinationally.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= WAIT_LOCK;
         hold_cnt  <= '0;
         cause     <= RST_CAUSE_POR;
         rst_cnt   <= '0;
         sys_rst_n <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_nxt;
         cause     <= cause_nxt;
         rst_cnt   <= cnt_nxt;
         sys_rst_n <= (state_nxt == RUN);
      end
   end

   always_comb begin
      state_nxt = state;
      hold_nxt  = '0;
      cause_nxt = cause;
      cnt_nxt   = rst_cnt;
      hold_ok   = sync_locked && deb_btn_n && !rst_bus.sw_rst_req;
      case (state)
         WAIT_LOCK: begin
            if (sync_locked && deb_btn_n) state_nxt = HOLD;
         end
         HOLD: begin
            // Any dirty cycle restarts the hold window; a held sw request parks here.
            if (!sync_locked) begin
               state_nxt = WAIT_LOCK;
            end else if (hold_ok) begin
               if (hold_cnt == HW'(HOLD_CYC - 1)) state_nxt = RUN;
               else                               hold_nxt  = hold_cnt + HW'(1);
            end
         end
         RUN: begin
            // Cause/count latch only here, highest-priority source wins.
            if (!sync_locked) begin
               state_nxt = WAIT_LOCK;
               cause_nxt = RST_CAUSE_PLL;
               cnt_nxt   = sat_inc8(rst_cnt);
            end else if (!deb_btn_n) begin
               state_nxt = HOLD;
               cause_nxt = RST_CAUSE_BTN;
               cnt_nxt   = sat_inc8(rst_cnt);
            end else if (rst_bus.sw_rst_req) begin
               state_nxt = HOLD;
               cause_nxt = RST_CAUSE_SW;
               cnt_nxt   = sat_inc8(rst_cnt);
            end
         end
         default: state_nxt = WAIT_LOCK;
      endcase
   end

   assign rst_bus.sys_rst_n = sys_rst_n;
   assign rst_bus.rst_busy  = (state != RUN);
   assign rst_bus.rst_cause = cause;
   assign rst_bus.rst_cnt   = rst_cnt;
endmodule

// File: tb/tb_fpga_rst_seq.sv
module tb_fpga_rst_seq;
   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   fpga_rst_seq_if bus();

   fpga_rst_seq #(
      .SYNC_STAGES  (2),
      .DEBOUNCE_CYC (8),
      .HOLD_CYC     (16)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .rst_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance to 1 time unit after the next rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_run(input string tag, input int budget);
      int k;
      k = 0;
      while (bus.sys_rst_n !== 1'b1 && k < budget) begin
         step(1);
         k++;
      end
      n_cmp++;
      if (bus.sys_rst_n !== 1'b1) begin
         n_err++;
         $display("FAIL %s: sys_rst_n=%b after %0d cycles, required 1", tag, bus.sys_rst_n, budget);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.btn_rst_n = 1'b1; bus.pll_locked = 1'b1; bus.sw_rst_req = 1'b0;
      step(3);
      n_cmp++; if (bus.sys_rst_n !== 1'b0) begin n_err++; $display("FAIL por_sys: got %b want 0", bus.sys_rst_n); end
      n_cmp++; if (bus.rst_busy !== 1'b1) begin n_err++; $display("FAIL por_busy: got %b want 1", bus.rst_busy); end
      n_cmp++; if (bus.rst_cause !== 2'b00) begin n_err++; $display("FAIL por_cause: got %b want 00", bus.rst_cause); end
      n_cmp++; if (bus.rst_cnt !== 8'd0) begin n_err++; $display("FAIL por_cnt: got %0d want 0", bus.rst_cnt); end
      rst_n = 1'b1;
      step(18);
      n_cmp++; if (bus.sys_rst_n !== 1'b0) begin n_err++; $display("FAIL por_early: got %b want 0 at edge 18", bus.sys_rst_n); end
      step(1);
      n_cmp++; if (bus.sys_rst_n !== 1'b1) begin n_err++; $display("FAIL por_release: got %b want 1 at edge 19", bus.sys_rst_n); end
      n_cmp++; if (bus.rst_busy !== 1'b0) begin n_err++; $display("FAIL por_run_busy: got %b want 0", bus.rst_busy); end
      n_cmp++; if (bus.rst_cause !== 2'b00 || bus.rst_cnt !== 8'd0) begin n_err++; $display("FAIL por_run_stat: cause=%b cnt=%0d want 00/0", bus.rst_cause, bus.rst_cnt); end
   endtask

   task automatic test_bounce();
      for (int r = 0; r < 6; r++) begin
         bus.btn_rst_n = 1'b0;
         for (int c = 0; c < 5; c++) begin
            step(1);
            n_cmp++; if (bus.sys_rst_n !== 1'b1) begin n_err++; $display("FAIL bounce_low r%0d c%0d: got %b want 1", r, c, bus.sys_rst_n); end
         end
         bus.btn_rst_n = 1'b1;
         for (int c = 0; c < 5; c++) begin
            step(1);
            n_cmp++; if (bus.sys_rst_n !== 1'b1) begin n_err++; $display("FAIL bounce_high r%0d c%0d: got %b want 1", r, c, bus.sys_rst_n); end
         end
      end
      step(10);
      n_cmp++; if (bus.sys_rst_n !== 1'b1 || bus.rst_cnt !== 8'd0) begin n_err++; $display("FAIL bounce_settle: sys=%b cnt=%0d want 1/0", bus.sys_rst_n, bus.rst_cnt); end
   endtask

   task automatic test_press();
      bus.btn_rst_n = 1'b0;
      step(10);
      n_cmp++; if (bus.sys_rst_n !== 1'b1) begin n_err++; $display("FAIL press_early: got %b want 1 at edge 10", bus.sys_rst_n); end
      step(1);
      n_cmp++; if (bus.sys_rst_n !== 1'b0) begin n_err++; $display("FAIL press_drop: got %b want 0 at edge 11", bus.sys_rst_n); end
      n_cmp++; if (bus.rst_cause !== 2'b01) begin n_err++; $display("FAIL press_cause: got %b want 01", bus.rst_cause); end
      n_cmp++; if (bus.rst_cnt !== 8'd1) begin n_err++; $display("FAIL press_cnt: got %0d want 1", bus.rst_cnt); end
      step(9);
      bus.btn_rst_n = 1'b1;
      step(25);
      n_cmp++; if (bus.sys_rst_n !== 1'b0) begin n_err++; $display("FAIL release_early: got %b want 0 at edge 25", bus.sys_rst_n); end
      step(1);
      n_cmp++; if (bus.sys_rst_n !== 1'b1) begin n_err++; $display("FAIL release_run: got %b want 1 at edge 26", bus.sys_rst_n); end
      n_cmp++; if (bus.rst_cnt !== 8'd1 || bus.rst_cause !== 2'b01) begin n_err++; $display("FAIL release_stat: cause=%b cnt=%0d want 01/1", bus.rst_cause, bus.rst_cnt); end
   endtask

   task automatic test_lock_drop();
      bus.pll_locked = 1'b0;
      step(1);
      bus.pll_locked = 1'b1;
      step(1);
      n_cmp++; if (bus.sys_rst_n !== 1'b1) begin n_err++; $display("FAIL lock_early: got %b want 1 at edge 2", bus.sys_rst_n); end
      step(1);
      n_cmp++; if (bus.sys_rst_n !== 1'b0) begin n_err++; $display("FAIL lock_drop: got %b want 0 at edge 3", bus.sys_rst_n); end
      n_cmp++; if (bus.rst_cause !== 2'b10 || bus.rst_cnt !== 8'd2) begin n_err++; $display("FAIL lock_stat: cause=%b cnt=%0d want 10/2", bus.rst_cause, bus.rst_cnt); end
      step(16);
      n_cmp++; if (bus.sys_rst_n !== 1'b0) begin n_err++; $display("FAIL relock_early: got %b want 0 at edge 19", bus.sys_rst_n); end
      step(1);
      n_cmp++; if (bus.sys_rst_n !== 1'b1) begin n_err++; $display("FAIL relock_run: got %b want 1 at edge 20", bus.sys_rst_n); end
   endtask

   task automatic test_sw_pulse();
      bus.sw_rst_req = 1'b1;
      step(1);
      bus.sw_rst_req = 1'b0;
      n_cmp++; if (bus.sys_rst_n !== 1'b0) begin n_err++; $display("FAIL sw_drop: got %b want 0", bus.sys_rst_n); end
      n_cmp++; if (bus.rst_cause !== 2'b11 || bus.rst_cnt !== 8'd3) begin n_err++; $display("FAIL sw_stat: cause=%b cnt=%0d want 11/3", bus.rst_cause, bus.rst_cnt); end
      step(15);
      n_cmp++; if (bus.sys_rst_n !== 1'b0) begin n_err++; $display("FAIL sw_early: got %b want 0 at edge 16", bus.sys_rst_n); end
      step(1);
      n_cmp++; if (bus.sys_rst_n !== 1'b1) begin n_err++; $display("FAIL sw_run: got %b want 1 at edge 17", bus.sys_rst_n); end
   endtask

   task automatic test_sw_level();
      bus.sw_rst_req = 1'b1;
      step(1);
      n_cmp++; if (bus.sys_rst_n !== 1'b0 || bus.rst_cnt !== 8'd4) begin n_err++; $display("FAIL swlvl_drop: sys=%b cnt=%0d want 0/4", bus.sys_rst_n, bus.rst_cnt); end
      step(39);
      bus.sw_rst_req = 1'b0;
      n_cmp++; if (bus.sys_rst_n !== 1'b0 || bus.rst_cnt !== 8'd4 || bus.rst_cause !== 2'b11) begin n_err++; $display("FAIL swlvl_held: sys=%b cnt=%0d cause=%b want 0/4/11", bus.sys_rst_n, bus.rst_cnt, bus.rst_cause); end
      step(15);
      n_cmp++; if (bus.sys_rst_n !== 1'b0) begin n_err++; $display("FAIL swlvl_early: got %b want 0", bus.sys_rst_n); end
      step(1);
      n_cmp++; if (bus.sys_rst_n !== 1'b1 || bus.rst_cnt !== 8'd4) begin n_err++; $display("FAIL swlvl_run: sys=%b cnt=%0d want 1/4", bus.sys_rst_n, bus.rst_cnt); end
   endtask

   task automatic test_simultaneous();
      bus.btn_rst_n = 1'b0;
      step(8);
      bus.pll_locked = 1'b0;
      step(2);
      bus.sw_rst_req = 1'b1;
      n_cmp++; if (bus.sys_rst_n !== 1'b1) begin n_err++; $display("FAIL simul_pre: got %b want 1 at edge 10", bus.sys_rst_n); end
      step(1);
      bus.sw_rst_req = 1'b0;
      n_cmp++; if (bus.sys_rst_n !== 1'b0 || bus.rst_busy !== 1'b1) begin n_err++; $display("FAIL simul_drop: sys=%b busy=%b want 0/1", bus.sys_rst_n, bus.rst_busy); end
      n_cmp++; if (bus.rst_cause !== 2'b10 || bus.rst_cnt !== 8'd5) begin n_err++; $display("FAIL simul_cause: cause=%b cnt=%0d want 10/5", bus.rst_cause, bus.rst_cnt); end
      bus.btn_rst_n  = 1'b1;
      bus.pll_locked = 1'b1;
      step(15);
      n_cmp++; if (bus.sys_rst_n !== 1'b0 || bus.rst_cnt !== 8'd5) begin n_err++; $display("FAIL hold_pre: sys=%b cnt=%0d want 0/5", bus.sys_rst_n, bus.rst_cnt); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.sys_rst_n !== 1'b0 || bus.rst_busy !== 1'b1) begin n_err++; $display("FAIL async_out: sys=%b busy=%b want 0/1", bus.sys_rst_n, bus.rst_busy); end
      n_cmp++; if (bus.rst_cause !== 2'b00 || bus.rst_cnt !== 8'd0) begin n_err++; $display("FAIL async_stat: cause=%b cnt=%0d want 00/0", bus.rst_cause, bus.rst_cnt); end
      step(2);
      rst_n = 1'b1;
      wait_run("async_recover", 40);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) begin
         bus.sw_rst_req = 1'b1;
         step(1);
         bus.sw_rst_req = 1'b0;
         wait_run("sat_run", 40);
         if (i == 99) begin
            n_cmp++; if (bus.rst_cnt !== 8'd100) begin n_err++; $display("FAIL sat_mid: got %0d want 100", bus.rst_cnt); end
         end
         if (i == 254) begin
            n_cmp++; if (bus.rst_cnt !== 8'd255) begin n_err++; $display("FAIL sat_reach: got %0d want 255", bus.rst_cnt); end
         end
      end
      n_cmp++; if (bus.rst_cnt !== 8'd255 || bus.rst_cause !== 2'b11) begin n_err++; $display("FAIL sat_end: cnt=%0d cause=%b want 255/11", bus.rst_cnt, bus.rst_cause); end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_press();
      test_lock_drop();
      test_sw_pulse();
      test_sw_level();
      test_simultaneous();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
